// File: rtl/trace_buffer_if.sv
// Commit-side and record-side bus of the trace buffer.
// Master is the core/consumer, slave is the buffer.
interface trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_inst;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic              rec_valid;
  logic              rec_ready;
  logic [3*XLEN+5:0] rec_data;

  modport master (
    output commit_valid, commit_pc, commit_inst,
    output rf_we, rf_waddr, rf_wdata,
    output rec_ready,
    input  rec_valid, rec_data
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst,
    input  rf_we, rf_waddr, rf_wdata,
    input  rec_ready,
    output rec_valid, rec_data
  );
endinterface

// File: rtl/trace_buffer.sv
// Commit trace capture: armed session, optional rf_we filter,
// FWFT record FIFO with drop accounting.
module trace_buffer #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 64,
  parameter int MAX_REC = 1200,
  parameter int FILTER  = 0
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         arm,
  trace_buffer_if.slave                bus,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [31:0]                  rec_count,
  output logic [15:0]                  drop_count,
  output logic [1:0]                   state
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int RW = 3*XLEN+6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [31:0]   rec_count_q, rec_count_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] rec_in;
  logic qual, pop, push, drop, hit;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      level_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      rec_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      rec_count_q  <= rec_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wptr_q] <= rec_in;
  end

  // Datapath: qualify, push/pop, counters
  always_comb begin
    rec_in = {bus.commit_pc, bus.commit_inst, bus.rf_we,
              bus.rf_we ? bus.rf_waddr : 5'd0,
              bus.rf_we ? bus.rf_wdata : {XLEN{1'b0}}};
    qual = (state_q == S_CAP) & bus.commit_valid
         & ((FILTER == 0) | bus.rf_we) & ~arm;
    pop  = (level_q != '0) & bus.rec_ready;
    push = qual & ((level_q != LW'(DEPTH)) | pop);
    drop = qual & ~push;
    hit  = qual & (rec_count_q == 32'(MAX_REC - 1));

    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q;
    if (push & ~pop) level_d = level_q + LW'(1);
    if (pop & ~push) level_d = level_q - LW'(1);

    rec_count_d  = rec_count_q + 32'(qual);
    drop_count_d = drop_count_q;
    if (drop & (drop_count_q != 16'hFFFF))
      drop_count_d = drop_count_q + 16'd1;
    if (arm) begin
      rec_count_d  = '0;
      drop_count_d = '0;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (arm) begin
      state_d = S_CAP;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_CAP:   state_d = hit ? S_DONE : S_CAP;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state         = state_q;
    level         = level_q;
    rec_count     = rec_count_q;
    drop_count    = drop_count_q;
    bus.rec_valid = (level_q != '0);
    bus.rec_data  = mem[rptr_q];
  end
endmodule
